// File: rtl/pong_pkg.sv
// Shared definitions for the pong command issuer: command word layout, strobe FSM states,
// default bar geometry and the bar position update helper.
package pong_pkg;

    localparam int Y_W        = 9;
    localparam int Y_INIT_DEF = 200;
    localparam int Y_MAX_DEF  = 440;

    localparam int CMD_Y_LSB   = 0;
    localparam int CMD_BAR_BIT = 9;
    localparam int CMD_INC_BIT = 10;
    localparam int CMD_ENA_BIT = 11;

    // One-hot so that each strobe-phase output can come straight off a state flop.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_SETUP = 4'b0010,
        ST_HIGH  = 4'b0100,
        ST_LOW   = 4'b1000
    } cmd_state_e;

    localparam int ST_IDLE_BIT = 0;
    localparam int ST_HIGH_BIT = 2;

    function automatic logic [Y_W-1:0] next_y(input logic [Y_W-1:0] y, input logic down,
                                              input int step, input int ymax);
        logic [Y_W:0] w;
        if (down) begin
            w = {1'b0, y} + 10'(step);
            if (w > 10'(ymax)) w = 10'(ymax);
        end else if ({1'b0, y} < 10'(step)) begin
            w = '0;
        end else begin
            w = {1'b0, y} - 10'(step);
        end
        return w[Y_W-1:0];
    endfunction

    function automatic logic [31:0] build_word(input logic [Y_W-1:0] y, input logic bar,
                                               input logic inc, input logic ena);
        logic [31:0] w;
        w = '0;
        w[CMD_Y_LSB +: Y_W] = y;
        w[CMD_BAR_BIT]      = bar;
        w[CMD_INC_BIT]      = inc;
        w[CMD_ENA_BIT]      = ena;
        return w;
    endfunction

endpackage

// File: rtl/pong_strobe_gen.sv
// SETUP (1 cycle) / HIGH (STROBE_W) / LOW (STROBE_W) command strobe sequencer.
// i_go is taken only in IDLE; o_done marks the last LOW cycle. No backpressure beyond o_busy.
module pong_strobe_gen
    import pong_pkg::*;
#(
    parameter int STROBE_W = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_go,
    output logic o_cmd_en,
    output logic o_busy,
    output logic o_idle,
    output logic o_done
);

    localparam int CW = (STROBE_W > 1) ? $clog2(STROBE_W) : 1;

    cmd_state_e r_state;
    cmd_state_e w_nxt;
    logic [CW-1:0] r_cnt;
    logic w_cnt_last;

    assign w_cnt_last = (r_cnt == CW'(STROBE_W - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt;
            if ((r_state == ST_HIGH || r_state == ST_LOW) && !w_cnt_last)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (i_go) w_nxt = ST_SETUP;
            ST_SETUP: w_nxt = ST_HIGH;
            ST_HIGH:  if (w_cnt_last) w_nxt = ST_LOW;
            ST_LOW:   if (w_cnt_last) w_nxt = ST_IDLE;
            default:  w_nxt = ST_IDLE;
        endcase
    end

    // CMD_EN is the HIGH state flop itself, so reset drops it with no decode glitch.
    always_comb begin
        o_cmd_en = r_state[ST_HIGH_BIT];
        o_idle   = r_state[ST_IDLE_BIT];
        o_busy   = !r_state[ST_IDLE_BIT];
        o_done   = (r_state == ST_LOW) && w_cnt_last;
    end

endmodule

// File: rtl/pong_cmd_issuer.sv
// Issues enable/move command words to the pong game core: request -> SETUP next cycle, 2*STROBE_W+2 cycles to IDLE.
// Requests are dropped (not queued) while busy or rate-limited; PONG_SCORE_READBACK_EN enables score decode.
module pong_cmd_issuer
    import pong_pkg::*;
#(
    parameter int STEP     = 4,
    parameter int STROBE_W = 2,
    parameter int RATE_DIV = 1000,
    parameter int Y_INIT   = Y_INIT_DEF,
    parameter int Y_MAX    = Y_MAX_DEF
) (
    input  logic        CLK,
    input  logic        RST_BTN,
    input  logic        start_req,
    input  logic        up1,
    input  logic        dn1,
    input  logic        up2,
    input  logic        dn2,
    input  logic [31:0] result,
    output logic [31:0] CMD_DATA,
    output logic        CMD_EN,
    output logic        busy,
    output logic        game_on,
    output logic [14:0] score1,
    output logic [14:0] score2,
    output logic        score_valid
);

    localparam int RW = $clog2(RATE_DIV + 1);

    logic [31:0]    r_cmd_data;
    logic           r_game_on;
    logic           r_rr;
    logic [RW-1:0]  r_rate_cnt;
    logic [Y_W-1:0] r_y1, r_y2;

    logic           w_idle, w_done;
    logic           w_rate_ok, w_req1, w_req2, w_pick2;
    logic           w_start_go, w_move_go, w_go;
    logic [Y_W-1:0] w_ny1, w_ny2;
    logic [31:0]    w_move_word;

    pong_strobe_gen #(.STROBE_W(STROBE_W)) u_strobe (
        .i_clk    (CLK),
        .i_rst_n  (RST_BTN),
        .i_go     (w_go),
        .o_cmd_en (CMD_EN),
        .o_busy   (busy),
        .o_idle   (w_idle),
        .o_done   (w_done)
    );

    assign w_rate_ok = (r_rate_cnt == RW'(RATE_DIV - 1));
    assign w_ny1     = next_y(r_y1, dn1, STEP, Y_MAX);
    assign w_ny2     = next_y(r_y2, dn2, STEP, Y_MAX);
    // A request pinned at its clamp limit produces no change, hence no command.
    assign w_req1    = (up1 ^ dn1) && (w_ny1 != r_y1);
    assign w_req2    = (up2 ^ dn2) && (w_ny2 != r_y2);
    assign w_pick2   = w_req2 && (!w_req1 || r_rr);

    assign w_start_go  = !r_game_on && w_idle && start_req;
    assign w_move_go   = r_game_on && w_idle && w_rate_ok && (w_req1 || w_req2);
    assign w_go        = w_start_go || w_move_go;
    assign w_move_word = build_word(w_pick2 ? w_ny2 : w_ny1, w_pick2, w_pick2 ? dn2 : dn1, 1'b0);

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_cmd_data <= '0;
            r_game_on  <= 1'b0;
            r_rr       <= 1'b0;
            r_rate_cnt <= '0;
            r_y1       <= Y_W'(Y_INIT);
            r_y2       <= Y_W'(Y_INIT);
        end else begin
            if (w_start_go) begin
                r_game_on  <= 1'b1;
                r_cmd_data <= build_word('0, 1'b0, 1'b0, 1'b1);
            end
            if (w_move_go) begin
                r_cmd_data <= w_move_word;
                r_rr       <= ~r_rr;
                r_rate_cnt <= '0;
                if (w_pick2) r_y2 <= w_ny2;
                else         r_y1 <= w_ny1;
            end else if (!w_rate_ok) begin
                r_rate_cnt <= r_rate_cnt + 1'b1;
            end
        end
    end

    assign CMD_DATA = r_cmd_data;
    assign game_on  = r_game_on;

`ifdef PONG_SCORE_READBACK_EN
    logic [14:0] r_score1, r_score2;
    logic        r_score_vld;

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_score1    <= '0;
            r_score2    <= '0;
            r_score_vld <= 1'b0;
        end else begin
            r_score_vld <= w_done && (result[16] || result[0]);
            if (w_done && result[16]) r_score1 <= result[31:17];
            if (w_done && result[0])  r_score2 <= result[15:1];
        end
    end

    assign score1      = r_score1;
    assign score2      = r_score2;
    assign score_valid = r_score_vld;
`else
    logic w_unused_readback;
    assign w_unused_readback = ^{result, w_done};
    assign score1      = '0;
    assign score2      = '0;
    assign score_valid = 1'b0;
`endif

endmodule

// File: doc/pong_cmd_issuer.md
PONG_CMD_ISSUER -- requirements
Module: pong_cmd_issuer

Interface
REQ-001 Parameter STEP, default 4: bar y change per move command, in pixels.
REQ-002 Parameter STROBE_W, default 2: CMD_EN high-phase and low-phase width, in CLK cycles.
REQ-003 Parameter RATE_DIV, default 1000: minimum CLK cycles from one move command's SETUP to the next.
REQ-004 Parameter Y_INIT, default 200; Parameter Y_MAX, default 440: initial and maximum tracked bar y.
REQ-005 CLK  in  1  single clock; all state on rising edge.
REQ-006 RST_BTN  in  1  asynchronous, active-low reset.
REQ-007 start_req  in  1  one-cycle pulse requesting game enable.
REQ-008 up1, dn1, up2, dn2  in  1  level move requests, bar 1 and bar 2.
REQ-009 result  in  32  game readback word: [31:17] score1, [16] dirty1, [15:1] score2, [0] dirty2.
REQ-010 CMD_DATA  out  32  command word to the game's dataa input.
REQ-011 CMD_EN  out  1  command strobe to the game's CLK_EN input.
REQ-012 busy  out  1  high while a command is in flight.
REQ-013 game_on  out  1  high once the enable command has been issued.
REQ-014 score1, score2  out  15 each  last decoded scores.
REQ-015 score_valid  out  1  one-cycle pulse when either score updates.

Function
REQ-016 Command word SHALL be: [8:0] y, [9] bar select (0=bar1), [10] incDec (1=increment), [11] enable; [31:12]=0.
REQ-017 FSM states SHALL be IDLE, SETUP, HIGH, LOW.
- SETUP: 1 cycle, CMD_DATA driven, CMD_EN=0.
- HIGH: STROBE_W cycles, CMD_EN=1.
- LOW: STROBE_W cycles, CMD_EN=0.
- Then return to IDLE.
REQ-018 CMD_DATA SHALL hold stable from SETUP through the last LOW cycle.
REQ-019 busy SHALL be 1 in SETUP, HIGH and LOW; 0 in IDLE.
REQ-020 Latency: start_req at cycle N -> SETUP at N+1, CMD_EN high N+2..N+1+STROBE_W, IDLE at N+2+2*STROBE_W.
REQ-021 With game_on=0, only start_req is acted on; the issued word has y=0, bit11=1, and game_on sets on entering SETUP.
REQ-022 start_req with game_on=1 SHALL be ignored.
REQ-023 Move requests SHALL be ignored while game_on=0 or busy=1, or before RATE_DIV has elapsed.
REQ-024 Up SHALL decrement y (incDec=0); down SHALL increment y (incDec=1).
REQ-025 Up and down asserted together on one bar SHALL mean no request for that bar.
REQ-026 New y SHALL be computed in 10 bits and clamped to [0, Y_MAX].
REQ-027 A request at the clamp limit in its direction SHALL issue no command.
REQ-028 Tracked y SHALL update on entering SETUP.
REQ-029 When both bars request in the same cycle, service SHALL be round-robin; the pointer starts at bar 1 after reset and toggles after each move command.

Reset
REQ-030 RST_BTN low SHALL immediately force IDLE and CMD_EN=0, with no glitch-high.
REQ-031 RST_BTN low SHALL also force CMD_DATA=0, busy=0, game_on=0, scores=0, score_valid=0, rate counter=0, and both tracked y=Y_INIT.
REQ-032 Reset mid-strobe SHALL abort the command; no resume after release.

Configuration
REQ-033 Macro PONG_SCORE_READBACK_EN defined: result SHALL be sampled in the last LOW cycle of each command.
- dirty1=1 loads score1; dirty2=1 loads score2.
- score_valid pulses on the next cycle if either dirty bit was set.
REQ-034 Macro undefined: result SHALL be ignored, and score1, score2 and score_valid SHALL be constant 0.

Structure
REQ-035 Shared package pong_pkg SHALL hold the word bit-position constants, the FSM state enum and the Y_MAX/Y_INIT defaults.
REQ-036 Sub-module pong_strobe_gen SHALL implement the SETUP/HIGH/LOW timing with a go/done handshake.

Verification
REQ-037 Reset, then start_req at cycle 10 -> CMD_DATA=0x00000800 at cycle 11, CMD_EN high cycles 12-13, game_on=1, busy low at 16.
REQ-038 game_on=1, dn1 held -> words 0x000004CC, then 0x000004D0 no earlier than 1000 cycles after the first SETUP.
REQ-039 up2 held from y=4 -> one word 0x00000200 (y=0), then no further commands.
REQ-040 up1 and dn2 in the same cycle after reset -> bar 1 command first, then a bar 2 command with y=204.
REQ-041 RST_BTN low during a HIGH cycle -> CMD_EN=0 the same cycle, game_on=0, y=200 after release.
REQ-042 PONG_SCORE_READBACK_EN defined, result=0x00070005 during a command -> score1=3, score2=2, single score_valid pulse.
